ethernet_rx_frame_parser: RTL and testbench
===========================================

// Module: ethernet_rx_frame_parser
// PURPOSE
//  Consumes the 8-bit Ethernet byte stream (i_data/i_valid, one frame per i_valid burst) produced by the fake
//  transmitter / PHY-side source. Strips preamble+SFD, filters on destination MAC, captures src MAC and ethertype,
//  classifies ARP/ICMP/UDP, forwards payload bytes with SOF/EOF framing to the ARP/IP handlers downstream.
//  Frames carry no FCS.
// PARAMETERS
//  P_LOCAL_MAC    48'h211abcdef112  accepted unicast destination MAC (broadcast FF..FF also accepted)
//  P_MAX_PAYLOAD  1500              max payload bytes; longer frame -> error
// PORTS
//  i_clk           in   1   clock
//  i_reset         in   1   synchronous, active-high reset
//  i_data          in   8   stream byte, valid when i_valid
//  i_valid         in   1   high for every byte of a frame, contiguous; low >=1 cycle between frames
//  o_data          out  8   payload byte
//  o_valid         out  1   o_data valid
//  o_sof           out  1   with first payload byte
//  o_eof           out  1   with last payload byte
//  o_src_mac       out  48  source MAC, stable from first payload byte until next frame header completes
//  o_ethertype     out  16  ethertype, same stability as o_src_mac
//  o_frame_type    out  2   00 other, 01 ARP, 10 IPv4/ICMP, 11 IPv4/UDP; valid with o_frame_done
//  o_frame_done    out  1   1-cycle pulse: accepted frame completed
//  o_frame_err     out  1   1-cycle pulse: malformed frame discarded
// BEHAVIOUR
//  Reset: all outputs 0; FSM -> S_IDLE; counters 0. Reset mid-frame abandons it; no done/err emitted for it.
//  FSM (advances only on cycles with i_valid=1 except where noted):
//   S_IDLE:  byte 0x55 -> S_PRE; any other byte -> S_DROP.
//   S_PRE:   0x55 -> stay (preamble length 1..7 accepted, 8th 0x55 -> err); 0xD5 -> S_HDR; else err.
//   S_HDR:   14 bytes, hdr_cnt 0..13. Bytes 0-5 dest MAC (MSB first), 6-11 src MAC, 12-13 ethertype.
//            After byte 5: dest != P_LOCAL_MAC and != broadcast -> S_DROP silently (no err, no done).
//            After byte 13: latch o_src_mac/o_ethertype -> S_PAY.
//   S_PAY:   each byte counted (pay_cnt, 11 bit) and forwarded. If ethertype==0x0800, payload byte 9 = IP
//            protocol: 0x01 -> ICMP, 0x11 -> UDP, else other. ethertype 0x0806 -> ARP. pay_cnt reaching
//            P_MAX_PAYLOAD+1 -> err, S_DROP, o_eof NOT issued for truncated frame (downstream discards on err).
//   S_DROP:  ignore bytes until i_valid=0 -> S_IDLE.
//  i_valid falling (i_valid=0 in any state != S_IDLE): S_PRE/S_HDR -> err pulse (runt); S_PAY -> done; -> S_IDLE.
//  Payload output via 1-byte hold register: byte k is emitted (o_valid=1) on the cycle after byte k+1 is sampled;
//   last byte emitted the cycle after i_valid=0 is sampled, with o_eof=1 and o_frame_done=1 in the same cycle.
//   Zero-length payload: o_frame_done alone, no o_valid. Single-byte payload: o_sof=o_eof=1.
//  o_frame_err and o_frame_done never asserted together. err pulse issued the cycle after the offending byte/edge.
//  Back-to-back frames with 1 idle cycle: last-byte flush of frame N and first preamble byte of N+1 both handled.
// STRUCTURE
//  ethernet_rx_pkg: ETH_PREAMBLE 8'h55, ETH_SFD 8'hD5, ETYPE_ARP 16'h0806, ETYPE_IPV4 16'h0800, IP_PROTO_ICMP
//   8'h01, IP_PROTO_UDP 8'h11, frame type codes FT_OTHER/FT_ARP/FT_ICMP/FT_UDP, FSM state encodings.
//  Sub-module ethernet_rx_byte_hold: 1-byte hold register generating o_valid/o_sof/o_eof from push/flush.
// TESTING (driven by tb_ethernet_fake_data_transmitter, plus directed byte injector)
//  1 ARP frame (50 bytes) -> 28 payload bytes, first 0x00 with sof, last 0x86 with eof; src 40b0769ea12e,
//    ethertype 0806, frame_type 01, one done pulse, no err.
//  2 ICMP then UDP (82 bytes each, 1 idle gap) -> 60 payload bytes each; frame_type 10 then 11; UDP first
//    payload byte 0x45, last 0x78.
//  3 dest MAC 02..00:01 (not local) -> no o_valid, no done, no err; next valid ARP frame parsed normally.
//  4 Runt: valid drops after 10 bytes (in header) -> one err pulse, no payload; bad SFD 0xD4 -> err, drop rest.
//  5 Reset asserted mid-payload of ICMP -> all outputs 0 next cycle; tail bytes dropped; next frame OK.
//  6 P_MAX_PAYLOAD=32 with 60-byte payload -> 32 bytes forwarded without eof, one err pulse, no done.

Source files
------------

// File: rtl/ethernet_rx_pkg.sv
// Shared constants, frame-type codes and FSM state encoding for the Ethernet RX parser.
package ethernet_rx_pkg;

   localparam logic [7:0]  ETH_PREAMBLE    = 8'h55;
   localparam logic [7:0]  ETH_SFD         = 8'hD5;
   localparam logic [15:0] ETYPE_ARP       = 16'h0806;
   localparam logic [15:0] ETYPE_IPV4      = 16'h0800;
   localparam logic [7:0]  IP_PROTO_ICMP   = 8'h01;
   localparam logic [7:0]  IP_PROTO_UDP    = 8'h11;
   localparam logic [47:0] MAC_BROADCAST   = 48'hFFFF_FFFF_FFFF;

   localparam int HDR_LEN         = 14;
   localparam int HDR_DST_LAST    = 5;
   localparam int PRE_MAX         = 7;
   localparam int IP_PROTO_OFFSET = 9;

   typedef enum logic [1:0] {
      FT_OTHER = 2'b00,
      FT_ARP   = 2'b01,
      FT_ICMP  = 2'b10,
      FT_UDP   = 2'b11
   } frame_type_t;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_PRE  = 3'd1,
      S_HDR  = 3'd2,
      S_PAY  = 3'd3,
      S_DROP = 3'd4
   } state_t;

endpackage

// File: rtl/ethernet_rx_frame_parser_byte_hold.sv
// One-byte hold stage: delays payload by one byte so the final byte can be tagged with EOF.
module ethernet_rx_byte_hold (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic       i_push,
   input  logic [7:0] i_push_data,
   input  logic       i_flush,
   input  logic       i_drain,
   output logic [7:0] o_data,
   output logic       o_valid,
   output logic       o_sof,
   output logic       o_eof
);

   logic [7:0] held_data_reg;
   logic       held_valid_reg;
   logic       held_first_reg;
   logic       in_frame_reg;

   // flush releases the held byte as the last one; drain releases it untagged (truncated frame)
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         o_data         <= 8'h00;
         o_valid        <= 1'b0;
         o_sof          <= 1'b0;
         o_eof          <= 1'b0;
         held_data_reg  <= 8'h00;
         held_valid_reg <= 1'b0;
         held_first_reg <= 1'b0;
         in_frame_reg   <= 1'b0;
      end else begin
         o_valid <= 1'b0;
         o_sof   <= 1'b0;
         o_eof   <= 1'b0;
         if (i_push) begin
            if (held_valid_reg) begin
               o_valid <= 1'b1;
               o_data  <= held_data_reg;
               o_sof   <= held_first_reg;
            end
            held_data_reg  <= i_push_data;
            held_valid_reg <= 1'b1;
            held_first_reg <= !in_frame_reg;
            in_frame_reg   <= 1'b1;
         end else if (i_flush || i_drain) begin
            if (held_valid_reg) begin
               o_valid <= 1'b1;
               o_data  <= held_data_reg;
               o_sof   <= held_first_reg;
               o_eof   <= i_flush;
            end
            held_valid_reg <= 1'b0;
            in_frame_reg   <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/ethernet_rx_frame_parser.sv
// Ethernet RX byte-stream parser: strips preamble/SFD, filters on destination MAC,
// captures source MAC and ethertype, classifies ARP/ICMP/UDP and forwards payload.
module ethernet_rx_frame_parser
   import ethernet_rx_pkg::*;
#(
   parameter logic [47:0] P_LOCAL_MAC   = 48'h211abcdef112,
   parameter int          P_MAX_PAYLOAD = 1500
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic [7:0]  i_data,
   input  logic        i_valid,
   output logic [7:0]  o_data,
   output logic        o_valid,
   output logic        o_sof,
   output logic        o_eof,
   output logic [47:0] o_src_mac,
   output logic [15:0] o_ethertype,
   output logic [1:0]  o_frame_type,
   output logic        o_frame_done,
   output logic        o_frame_err
);

   localparam logic [10:0] MAX_CNT = 11'(P_MAX_PAYLOAD);

   state_t      state_reg;
   logic [2:0]  pre_cnt_reg;
   logic [3:0]  hdr_cnt_reg;
   logic [10:0] pay_cnt_reg;
   logic [55:0] hdr_shift_reg;
   frame_type_t ftype_reg;

   logic        pay_byte;
   logic        overflow;
   logic        push;
   logic        flush;
   logic [47:0] dst_mac;
   logic [15:0] etype_now;

   assign pay_byte  = (state_reg == S_PAY) && i_valid;
   assign overflow  = pay_byte && (pay_cnt_reg == MAX_CNT);
   assign push      = pay_byte && !overflow;
   assign flush     = (state_reg == S_PAY) && !i_valid;
   assign dst_mac   = {hdr_shift_reg[39:0], i_data};
   assign etype_now = {hdr_shift_reg[7:0], i_data};

   ethernet_rx_byte_hold u_hold (
      .i_clk       (i_clk),
      .i_reset     (i_reset),
      .i_push      (push),
      .i_push_data (i_data),
      .i_flush     (flush),
      .i_drain     (overflow),
      .o_data      (o_data),
      .o_valid     (o_valid),
      .o_sof       (o_sof),
      .o_eof       (o_eof)
   );

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_reg     <= S_IDLE;
         pre_cnt_reg   <= 3'd0;
         hdr_cnt_reg   <= 4'd0;
         pay_cnt_reg   <= 11'd0;
         hdr_shift_reg <= 56'd0;
         ftype_reg     <= FT_OTHER;
         o_src_mac     <= 48'd0;
         o_ethertype   <= 16'd0;
         o_frame_type  <= 2'b00;
         o_frame_done  <= 1'b0;
         o_frame_err   <= 1'b0;
      end else begin
         o_frame_done <= 1'b0;
         o_frame_err  <= 1'b0;
         case (state_reg)
            S_IDLE: begin
               if (i_valid) begin
                  if (i_data == ETH_PREAMBLE) begin
                     state_reg   <= S_PRE;
                     pre_cnt_reg <= 3'd1;
                  end else begin
                     state_reg <= S_DROP;
                  end
               end
            end
            S_PRE: begin
               if (!i_valid) begin
                  o_frame_err <= 1'b1;
                  state_reg   <= S_IDLE;
               end else if (i_data == ETH_PREAMBLE) begin
                  if (pre_cnt_reg == 3'(PRE_MAX)) begin
                     o_frame_err <= 1'b1;
                     state_reg   <= S_DROP;
                  end else begin
                     pre_cnt_reg <= pre_cnt_reg + 3'd1;
                  end
               end else if (i_data == ETH_SFD) begin
                  state_reg   <= S_HDR;
                  hdr_cnt_reg <= 4'd0;
               end else begin
                  o_frame_err <= 1'b1;
                  state_reg   <= S_DROP;
               end
            end
            S_HDR: begin
               if (!i_valid) begin
                  o_frame_err <= 1'b1;
                  state_reg   <= S_IDLE;
               end else begin
                  // 7-byte window: at the last header byte it holds src MAC plus ethertype high byte
                  hdr_shift_reg <= {hdr_shift_reg[47:0], i_data};
                  hdr_cnt_reg   <= hdr_cnt_reg + 4'd1;
                  if (hdr_cnt_reg == 4'(HDR_DST_LAST) &&
                      dst_mac != P_LOCAL_MAC && dst_mac != MAC_BROADCAST) begin
                     state_reg <= S_DROP;
                  end
                  if (hdr_cnt_reg == 4'(HDR_LEN - 1)) begin
                     o_src_mac   <= hdr_shift_reg[55:8];
                     o_ethertype <= etype_now;
                     ftype_reg   <= (etype_now == ETYPE_ARP) ? FT_ARP : FT_OTHER;
                     pay_cnt_reg <= 11'd0;
                     state_reg   <= S_PAY;
                  end
               end
            end
            S_PAY: begin
               if (!i_valid) begin
                  o_frame_done <= 1'b1;
                  o_frame_type <= ftype_reg;
                  state_reg    <= S_IDLE;
               end else if (overflow) begin
                  o_frame_err <= 1'b1;
                  state_reg   <= S_DROP;
               end else begin
                  pay_cnt_reg <= pay_cnt_reg + 11'd1;
                  if (pay_cnt_reg == 11'(IP_PROTO_OFFSET) && o_ethertype == ETYPE_IPV4) begin
                     if (i_data == IP_PROTO_ICMP)
                        ftype_reg <= FT_ICMP;
                     else if (i_data == IP_PROTO_UDP)
                        ftype_reg <= FT_UDP;
                     else
                        ftype_reg <= FT_OTHER;
                  end
               end
            end
            S_DROP: begin
               if (!i_valid)
                  state_reg <= S_IDLE;
            end
            default: state_reg <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ethernet_rx_frame_parser.sv
// Randomized scoreboard bench: instance 0 uses the default payload limit, instance 1 a 32-byte limit.
module tb_ethernet_rx_frame_parser;

   localparam logic [47:0] LOCAL_MAC = 48'h211abcdef112;
   localparam logic [47:0] SRC_A     = 48'h40b0769ea12e;
   localparam logic [47:0] SRC_B     = 48'h0a1b2c3d4e5f;
   localparam logic [47:0] BCAST     = 48'hffffffffffff;
   localparam logic [47:0] OTHER_MAC = 48'h020000000001;

   typedef struct packed {
      logic        inst;
      logic        v;
      logic [7:0]  d;
      logic        sof;
      logic        eof;
      logic        done;
      logic        err;
      logic [1:0]  ft;
      logic [47:0] src;
      logic [15:0] et;
   } rec_t;

   logic        clk;
   logic        rst;
   logic [7:0]  din   [2];
   logic        vin   [2];
   logic [7:0]  dout  [2];
   logic        vout  [2];
   logic        sof   [2];
   logic        eof   [2];
   logic [47:0] srcm  [2];
   logic [15:0] etm   [2];
   logic [1:0]  ft    [2];
   logic        done  [2];
   logic        err   [2];

   int          checks   = 0;
   int          failures = 0;
   rec_t        exp_q[$];
   logic [7:0]  frame_q[$];
   rec_t        mon_act;
   rec_t        mon_exp;

   for (genvar gi = 0; gi < 2; gi++) begin : g_dut
      ethernet_rx_frame_parser #(
         .P_LOCAL_MAC   (LOCAL_MAC),
         .P_MAX_PAYLOAD (gi == 0 ? 1500 : 32)
      ) u_dut (
         .i_clk        (clk),
         .i_reset      (rst),
         .i_data       (din[gi]),
         .i_valid      (vin[gi]),
         .o_data       (dout[gi]),
         .o_valid      (vout[gi]),
         .o_sof        (sof[gi]),
         .o_eof        (eof[gi]),
         .o_src_mac    (srcm[gi]),
         .o_ethertype  (etm[gi]),
         .o_frame_type (ft[gi]),
         .o_frame_done (done[gi]),
         .o_frame_err  (err[gi])
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic rec_t mk_rec(input int inst, input logic v, input logic [7:0] d,
                                   input logic s, input logic e, input logic dn, input logic er,
                                   input logic [1:0] f, input logic [47:0] src, input logic [15:0] et);
      rec_t r;
      r.inst = inst[0];
      r.v    = v;
      r.d    = v ? d : 8'h00;
      r.sof  = s;
      r.eof  = e;
      r.done = dn;
      r.err  = er;
      r.ft   = dn ? f : 2'b00;
      r.src  = (v || dn) ? src : 48'd0;
      r.et   = (v || dn) ? et : 16'd0;
      return r;
   endfunction

   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (vout[i] || done[i] || err[i]) begin
            mon_act = mk_rec(i, vout[i], dout[i], sof[i], eof[i], done[i], err[i], ft[i], srcm[i], etm[i]);
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL unexpected_output t=%0t got=%h required=none", $time, mon_act);
            end else begin
               mon_exp = exp_q.pop_front();
               if (mon_act !== mon_exp) begin
                  failures++;
                  $display("FAIL out_record t=%0t got=%h required=%h", $time, mon_act, mon_exp);
               end
            end
         end
      end
   end

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] req);
      checks++;
      if (got !== req) begin
         failures++;
         $display("FAIL %s got=%h required=%h", name, got, req);
      end
   endtask

   task automatic check_zero(input int i, input string tag);
      chk({tag, "_valid"}, 64'(vout[i]), 64'd0);
      chk({tag, "_data"},  64'(dout[i]), 64'd0);
      chk({tag, "_sofeof"}, 64'({sof[i], eof[i]}), 64'd0);
      chk({tag, "_donerr"}, 64'({done[i], err[i]}), 64'd0);
      chk({tag, "_ftype"}, 64'(ft[i]), 64'd0);
      chk({tag, "_src"},   64'(srcm[i]), 64'd0);
      chk({tag, "_etype"}, 64'(etm[i]), 64'd0);
   endtask

   // Reference model: decides the fate of one burst from its byte list alone.
   task automatic model_frame(input int inst, input int maxp);
      int n, h, len, plen;
      logic [47:0] dst, src;
      logic [15:0] et;
      logic [1:0]  f;
      len = frame_q.size();
      if (len == 0 || frame_q[0] != 8'h55) return;
      n = 0;
      while (n < len && frame_q[n] == 8'h55) n++;
      if (n >= 8 || n == len || frame_q[n] != 8'hD5) begin
         exp_q.push_back(mk_rec(inst, 0, 0, 0, 0, 0, 1, 0, 0, 0));
         return;
      end
      h = n + 1;
      if (len - h < 6) begin
         exp_q.push_back(mk_rec(inst, 0, 0, 0, 0, 0, 1, 0, 0, 0));
         return;
      end
      dst = '0;
      for (int i = 0; i < 6; i++) dst = {dst[39:0], frame_q[h + i]};
      if (dst != LOCAL_MAC && dst != BCAST) return;
      if (len - h < 14) begin
         exp_q.push_back(mk_rec(inst, 0, 0, 0, 0, 0, 1, 0, 0, 0));
         return;
      end
      src = '0;
      for (int i = 6; i < 12; i++) src = {src[39:0], frame_q[h + i]};
      et   = {frame_q[h + 12], frame_q[h + 13]};
      plen = len - h - 14;
      f = 2'b00;
      if (et == 16'h0806) f = 2'b01;
      else if (et == 16'h0800 && plen >= 10) begin
         if (frame_q[h + 14 + 9] == 8'h01) f = 2'b10;
         else if (frame_q[h + 14 + 9] == 8'h11) f = 2'b11;
      end
      if (plen > maxp) begin
         for (int k = 0; k < maxp; k++)
            exp_q.push_back(mk_rec(inst, 1, frame_q[h + 14 + k], k == 0, 0, 0, k == maxp - 1, 0, src, et));
      end else if (plen == 0) begin
         exp_q.push_back(mk_rec(inst, 0, 0, 0, 0, 1, 0, f, src, et));
      end else begin
         for (int k = 0; k < plen; k++)
            exp_q.push_back(mk_rec(inst, 1, frame_q[h + 14 + k], k == 0, k == plen - 1,
                                   k == plen - 1, 0, f, src, et));
      end
   endtask

   task automatic build_frame(input int pre_len, input logic [47:0] dst, input logic [47:0] src,
                              input logic [15:0] et, input int plen, input logic [7:0] proto);
      frame_q.delete();
      repeat (pre_len) frame_q.push_back(8'h55);
      frame_q.push_back(8'hD5);
      for (int i = 5; i >= 0; i--) frame_q.push_back(dst[i*8 +: 8]);
      for (int i = 5; i >= 0; i--) frame_q.push_back(src[i*8 +: 8]);
      frame_q.push_back(et[15:8]);
      frame_q.push_back(et[7:0]);
      for (int i = 0; i < plen; i++) frame_q.push_back((i == 9) ? proto : 8'($urandom));
   endtask

   // Called at posedge+1; returns at posedge+1 after one idle cycle has been sampled.
   task automatic drive_frame(input int inst);
      for (int i = 0; i < frame_q.size(); i++) begin
         din[inst] = frame_q[i];
         vin[inst] = 1'b1;
         @(posedge clk); #1;
      end
      vin[inst] = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic run(input int inst, input int maxp);
      model_frame(inst, maxp);
      drive_frame(inst);
   endtask

   task automatic random_frame(input int inst, input int maxp, input int pmax);
      logic [47:0] dst;
      logic [15:0] et;
      logic [7:0]  pr;
      int          cut;
      case ($urandom_range(0, 3))
         0: dst = OTHER_MAC;
         1: dst = BCAST;
         default: dst = LOCAL_MAC;
      endcase
      case ($urandom_range(0, 2))
         0: et = 16'h0806;
         1: et = 16'h86DD;
         default: et = 16'h0800;
      endcase
      case ($urandom_range(0, 2))
         0: pr = 8'h01;
         1: pr = 8'h11;
         default: pr = 8'h06;
      endcase
      build_frame($urandom_range(1, 8), dst, SRC_B ^ 48'($urandom), et, $urandom_range(0, pmax), pr);
      if ($urandom_range(0, 5) == 0) begin
         cut = $urandom_range(1, frame_q.size());
         while (frame_q.size() > cut) void'(frame_q.pop_back());
      end
      if ($urandom_range(0, 12) == 0) frame_q[0] = 8'hAA;
      run(inst, maxp);
   endtask

   initial begin
      logic [7:0] tail_q[$];
      int hdr_end;
      int j;
      rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         din[i] = 8'h00;
         vin[i] = 1'b0;
      end
      repeat (3) @(posedge clk);
      #1;
      check_zero(0, "reset0");
      check_zero(1, "reset1");
      rst = 1'b0;
      @(posedge clk); #1;

      // ARP; ICMP then UDP back-to-back; foreign dest then ARP
      build_frame(7, LOCAL_MAC, SRC_A, 16'h0806, 28, 8'h00);          run(0, 1500);
      build_frame(7, LOCAL_MAC, SRC_A, 16'h0800, 60, 8'h01);          run(0, 1500);
      build_frame(7, LOCAL_MAC, SRC_A, 16'h0800, 60, 8'h11);          run(0, 1500);
      build_frame(7, OTHER_MAC, SRC_A, 16'h0806, 28, 8'h00);          run(0, 1500);
      build_frame(7, LOCAL_MAC, SRC_B, 16'h0806, 28, 8'h00);          run(0, 1500);
      // runt in header, bad SFD, 8-byte preamble, short/zero/one-byte payloads
      build_frame(7, LOCAL_MAC, SRC_A, 16'h0806, 0, 8'h00);
      while (frame_q.size() > 10) void'(frame_q.pop_back());
      run(0, 1500);
      build_frame(7, LOCAL_MAC, SRC_A, 16'h0806, 20, 8'h00);
      frame_q[7] = 8'hD4;
      run(0, 1500);
      build_frame(8, LOCAL_MAC, SRC_A, 16'h0806, 20, 8'h00);          run(0, 1500);
      build_frame(1, BCAST,     SRC_B, 16'h0800, 0, 8'h00);           run(0, 1500);
      build_frame(3, LOCAL_MAC, SRC_A, 16'h0806, 1, 8'h00);           run(0, 1500);
      build_frame(2, LOCAL_MAC, SRC_B, 16'h0800, 9, 8'h00);           run(0, 1500);
      build_frame(2, LOCAL_MAC, SRC_B, 16'h0800, 10, 8'h11);          run(0, 1500);

      // reset in the middle of an ICMP payload
      build_frame(3, LOCAL_MAC, SRC_A, 16'h0800, 60, 8'h01);
      hdr_end = frame_q.size() - 60;
      j = 20;
      for (int k = 0; k < j - 1; k++)
         exp_q.push_back(mk_rec(0, 1, frame_q[hdr_end + k], k == 0, 0, 0, 0, 0, SRC_A, 16'h0800));
      for (int i = 0; i < hdr_end + j; i++) begin
         din[0] = frame_q[i];
         vin[0] = 1'b1;
         @(posedge clk); #1;
      end
      din[0] = frame_q[hdr_end + j];
      rst = 1'b1;
      @(posedge clk); #1;
      check_zero(0, "reset_mid");
      rst = 1'b0;
      tail_q.delete();
      for (int i = hdr_end + j + 1; i < frame_q.size(); i++) tail_q.push_back(frame_q[i]);
      frame_q = tail_q;
      run(0, 1500);
      build_frame(7, LOCAL_MAC, SRC_B, 16'h0806, 28, 8'h00);          run(0, 1500);

      for (int n = 0; n < 40; n++) random_frame(0, 1500, 70);
      repeat (3) @(posedge clk);
      #1;

      // 32-byte payload limit: overflow, exact fit, one over
      build_frame(7, LOCAL_MAC, SRC_A, 16'h0800, 60, 8'h01);          run(1, 32);
      build_frame(7, LOCAL_MAC, SRC_A, 16'h0806, 32, 8'h00);          run(1, 32);
      build_frame(7, LOCAL_MAC, SRC_B, 16'h0800, 33, 8'h11);          run(1, 32);
      for (int n = 0; n < 15; n++) random_frame(1, 32, 45);

      for (int t = 0; t < 100 && exp_q.size() != 0; t++) @(posedge clk);
      chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog got=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
